// File: rtl/frame_tap_mux.sv
// frame_tap_mux -- runtime-selectable 1-bit output tap for the UART CNN pipeline.
//
// This block reduces one of several streams to a 1-bit pixel stream. The
// source is the raw deframed stream, a single conv channel, or the gradient
// magnitude. The tap select comes from buttons. It is synchronised and
// debounced, and it only takes effect on a frame boundary. As a result, every
// frame that reaches the framer is complete and uses a single mode.
//
// Mode codes:
//   0                 : mag_data_i >= MagThresh (unsigned)
//   1..NumChannels    : chan[k-1] >= ChanThresh (signed)
//   NumChannels+1     : raw passthrough, raw_data_i[RawWidth-1]
//   higher codes      : ignored, the pending mode is kept
//
// Optional feature (macro FRAME_TAP_ABS_EN):
//   When defined, channel modes compare |chan| >= ChanThresh, so both gradient
//   polarities mark edges. When undefined, the compare is signed only.
//
// Ports:
//   clk_i, rst_i                : clock, asynchronous active-high reset
//   sel_i                       : asynchronous tap select (buttons)
//   raw_valid_i/raw_ready_o     : raw stream handshake
//   raw_data_i                  : raw element
//   feat_valid_i/feat_ready_o   : feature stream handshake
//   chan_data_i                 : packed signed channels, channel 0 in the LSBs
//   mag_data_i                  : magnitude, aligned with chan_data_i
//   valid_o/ready_i/data_o      : 1-bit output stream
//   mode_o                      : active mode
//   frame_done_o                : registered pulse, emitted alongside the
//                                 output of the last element of a frame
module frame_tap_mux #(
  parameter int NumChannels    = 2,
  parameter int ChanWidth      = 6,
  parameter int MagWidth       = 7,
  parameter int RawWidth       = 1,
  parameter int RawFrameElems  = 76800,
  parameter int FeatFrameElems = 75684,
  parameter int ChanThresh     = 2,
  parameter int MagThresh      = 4,
  parameter int DebounceCycles = 250000,
  parameter int SelWidth       = $clog2(NumChannels + 2)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [SelWidth-1:0]              sel_i,
  input  logic                             raw_valid_i,
  output logic                             raw_ready_o,
  input  logic [RawWidth-1:0]              raw_data_i,
  input  logic                             feat_valid_i,
  output logic                             feat_ready_o,
  input  logic [NumChannels*ChanWidth-1:0] chan_data_i,
  input  logic [MagWidth-1:0]              mag_data_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic                             data_o,
  output logic [SelWidth-1:0]              mode_o,
  output logic                             frame_done_o
);

  localparam int MaxElems = (RawFrameElems > FeatFrameElems) ? RawFrameElems : FeatFrameElems;
  localparam int CntWidth = $clog2(MaxElems);
  localparam int DbWidth  = $clog2(DebounceCycles + 1);
  localparam int ChanExtW = ChanWidth + 1;

  localparam logic [SelWidth-1:0]        RawMode  = SelWidth'(NumChannels + 1);
  localparam logic [CntWidth-1:0]        RawTerm  = CntWidth'(RawFrameElems - 1);
  localparam logic [CntWidth-1:0]        FeatTerm = CntWidth'(FeatFrameElems - 1);
  localparam logic [DbWidth-1:0]         DbLast   = DbWidth'(DebounceCycles - 1);
  localparam logic [DbWidth-1:0]         DbMax    = DbWidth'(DebounceCycles);
  localparam logic [MagWidth-1:0]        MagT     = MagWidth'(MagThresh);
  localparam logic signed [ChanExtW-1:0] ChanT    = ChanExtW'(ChanThresh);

  // The compare runs one bit wider than the channel. This lets the absolute
  // value of the most-negative code be represented without overflow.
  function automatic logic chan_edge(input logic signed [ChanWidth-1:0] c);
    logic signed [ChanExtW-1:0] ext;
    ext = {c[ChanWidth-1], c};
`ifdef FRAME_TAP_ABS_EN
    if (ext[ChanExtW-1]) ext = -ext;
`endif
    return ext >= ChanT;
  endfunction

  function automatic logic mag_edge(input logic [MagWidth-1:0] m);
    return m >= MagT;
  endfunction

  function automatic logic tap_bit(input logic [SelWidth-1:0]              m,
                                   input logic [NumChannels*ChanWidth-1:0] ch,
                                   input logic [MagWidth-1:0]              mg,
                                   input logic [RawWidth-1:0]              rw);
    logic b;
    b = mag_edge(mg);
    for (int k = 0; k < NumChannels; k++) begin
      if (m == SelWidth'(k + 1)) b = chan_edge(ch[k*ChanWidth +: ChanWidth]);
    end
    if (m == RawMode) b = rw[RawWidth-1];
    return b;
  endfunction

  logic [SelWidth-1:0] sel_sync_p0, sel_sync_p1, sel_last;
  logic [SelWidth-1:0] pending_mode, pending_next, mode;
  logic [DbWidth-1:0]  db_cnt;
  logic [CntWidth-1:0] elem_cnt;
  logic                raw_sel, in_valid, in_ready, accept, terminal, db_hit;

  assign raw_sel      = (mode == RawMode);
  assign in_ready     = ~valid_o | ready_i;
  assign in_valid     = raw_sel ? raw_valid_i : feat_valid_i;
  assign accept       = in_valid & in_ready;
  // The unselected stream is always drained, so upstream never stalls on it.
  assign raw_ready_o  = raw_sel ? in_ready : 1'b1;
  assign feat_ready_o = raw_sel ? 1'b1 : in_ready;
  assign terminal     = (elem_cnt == (raw_sel ? RawTerm : FeatTerm));
  assign mode_o       = mode;

  // A legal code that has been stable for the full debounce window loads on
  // this edge. pending_next is used so that a terminal accept on the same edge
  // picks up the fresh value.
  assign db_hit       = (sel_sync_p1 == sel_last) && (db_cnt == DbLast) && (sel_sync_p1 <= RawMode);
  assign pending_next = db_hit ? sel_sync_p1 : pending_mode;

  // Select stage: 2-FF synchroniser, then debounce
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_sync_p0  <= '0;
      sel_sync_p1  <= '0;
      sel_last     <= '0;
      db_cnt       <= '0;
      pending_mode <= '0;
    end else begin
      sel_sync_p0  <= sel_i;
      sel_sync_p1  <= sel_sync_p0;
      sel_last     <= sel_sync_p1;
      if (sel_sync_p1 != sel_last) db_cnt <= '0;
      else if (db_cnt != DbMax)    db_cnt <= db_cnt + 1'b1;
      pending_mode <= pending_next;
    end
  end

  // Frame stage: element counter and mode switch. The mode only changes while
  // the counter is at 0, either on the wrap itself or while idle at the start
  // of a frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      elem_cnt     <= '0;
      mode         <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (accept) begin
        if (terminal) begin
          elem_cnt     <= '0;
          frame_done_o <= 1'b1;
          mode         <= pending_next;
        end else begin
          elem_cnt <= elem_cnt + 1'b1;
        end
      end else if (elem_cnt == '0) begin
        mode <= pending_next;
      end
    end
  end

  // Output stage: single-register elastic slot
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= 1'b0;
    end else if (accept) begin
      valid_o <= 1'b1;
      data_o  <= tap_bit(mode, chan_data_i, mag_data_i, raw_data_i);
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_tap_mux.sv
module tb_frame_tap_mux;
  localparam int NC = 3, CW = 6, MW = 7, RW = 1;
  localparam int RAWN = 20, FEATN = 13, CT = 2, MT = 4, DB = 4;
  localparam int SW = $clog2(NC + 2);
  localparam int CHW = NC * CW;
  localparam int RAWMODE = NC + 1;

  logic clk = 1'b0, rst = 1'b0;
  logic [SW-1:0]  sel = '0;
  logic           raw_valid = 1'b0, feat_valid = 1'b0, ready = 1'b1;
  logic [RW-1:0]  raw_data = '0;
  logic [CHW-1:0] chan = '0;
  logic [MW-1:0]  mag = '0;
  logic           raw_ready, feat_ready, valid, data, frame_done;
  logic [SW-1:0]  mode;

  always #5 clk = ~clk;

  frame_tap_mux #(
    .NumChannels(NC), .ChanWidth(CW), .MagWidth(MW), .RawWidth(RW),
    .RawFrameElems(RAWN), .FeatFrameElems(FEATN), .ChanThresh(CT),
    .MagThresh(MT), .DebounceCycles(DB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .sel_i(sel),
    .raw_valid_i(raw_valid), .raw_ready_o(raw_ready), .raw_data_i(raw_data),
    .feat_valid_i(feat_valid), .feat_ready_o(feat_ready),
    .chan_data_i(chan), .mag_data_i(mag),
    .valid_o(valid), .ready_i(ready), .data_o(data),
    .mode_o(mode), .frame_done_o(frame_done)
  );

  int n_vec = 0, n_bad = 0;

  // Reference model state
  int m_mode, m_pend, m_idx;
  bit m_valid, m_data, m_fd;
  int h_val[$], h_run[$];

  int cv[8] = '{2, 1, -3, 5, -2, 31, -32, 0};
`ifdef FRAME_TAP_ABS_EN
  bit cexp[8] = '{1, 0, 1, 1, 1, 1, 1, 0};
`else
  bit cexp[8] = '{1, 0, 0, 1, 0, 1, 0, 0};
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int chan_val(input int k);
    int v;
    v = int'(chan[k*CW +: CW]);
    if (v >= (1 << (CW - 1))) v -= (1 << CW);
    return v;
  endfunction

  function automatic bit exp_bit(input int md);
    int v;
    if (md == 0) return int'(mag) >= MT;
    if (md == RAWMODE) return raw_data[RW-1];
    v = chan_val(md - 1);
`ifdef FRAME_TAP_ABS_EN
    if (v < 0) v = -v;
`endif
    return v >= CT;
  endfunction

  function automatic bit m_raw();
    return m_mode == RAWMODE;
  endfunction

  function automatic bit m_inrdy();
    return !m_valid || ready;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_idx = 0;
    m_valid = 0; m_data = 0; m_fd = 0;
    // Synchroniser contents after reset are zeros; the debounce run starts fresh.
    h_val = '{0, 0, 0};
    h_run = '{1, 2, 3};
  endtask

  // One clock of the specification's rules: a select sample counts once it is
  // two cycles old. It loads pending after DB+1 equal samples if it is legal.
  task automatic model_step();
    bit acc;
    int pnext, nr, term;
    acc = (m_raw() ? raw_valid : feat_valid) && m_inrdy();
    nr = (int'(sel) == h_val[2]) ? h_run[2] + 1 : 1;
    h_val.push_back(int'(sel));
    h_run.push_back(nr);
    pnext = m_pend;
    if (h_run[1] == DB + 1 && h_val[1] <= RAWMODE) pnext = h_val[1];
    void'(h_val.pop_front());
    void'(h_run.pop_front());
    term = m_raw() ? RAWN - 1 : FEATN - 1;
    m_fd = 0;
    if (acc) begin
      m_data  = exp_bit(m_mode);
      m_valid = 1;
      if (m_idx == term) begin
        m_idx = 0; m_fd = 1; m_mode = pnext;
      end else begin
        m_idx++;
      end
    end else begin
      if (ready) m_valid = 0;
      if (m_idx == 0) m_mode = pnext;
    end
    m_pend = pnext;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1;
    chk("raw_ready_o", raw_ready, m_raw() ? m_inrdy() : 1'b1);
    chk("feat_ready_o", feat_ready, m_raw() ? 1'b1 : m_inrdy());
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("valid_o", valid, m_valid);
    if (m_valid) chk("data_o", data, m_data);
    chk("mode_o", mode, m_mode);
    chk("frame_done_o", frame_done, m_fd);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst valid_o", valid, 0);
    chk("rst data_o", data, 0);
    chk("rst mode_o", mode, 0);
    chk("rst frame_done_o", frame_done, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_side();
    raw_valid = 1'($urandom);
    raw_data  = RW'($urandom);
    chan      = CHW'($urandom);
    mag       = MW'($urandom);
  endtask

  task automatic feed_feat(input int n);
    for (int k = 0; k < n; k++) begin
      rand_side(); feat_valid = 1'b1; ready = 1'b1;
      cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    bit seq[3] = '{1, 0, 1};
    #2;
    do_reset();

    // Default mode: magnitude alternating 3/4 over one feature frame
    sel = '0;
    for (int i = 0; i < FEATN; i++) begin
      rand_side(); feat_valid = 1'b1; ready = 1'b1;
      mag = MW'((i % 2) ? 4 : 3);
      cycle();
      chk("A data", data, i % 2);
      chk("A frame_done", frame_done, i == FEATN - 1);
      chk("A mode", mode, 0);
    end

    // Select changes mid-frame; mode switches only on the terminal accept
    for (int i = 0; i < FEATN; i++) begin
      if (i == 3) sel = SW'(1);
      rand_side(); feat_valid = 1'b1; ready = 1'b1;
      cycle();
      chk("B mode", mode, (i < FEATN - 1) ? 0 : 1);
    end

    // Channel 0 threshold, with signed values and the abs option
    for (int j = 0; j < 8; j++) begin
      rand_side(); feat_valid = 1'b1; ready = 1'b1;
      chan[CW-1:0] = CW'(cv[j]);
      cycle();
      chk("B chan0 edge", data, cexp[j]);
    end

    // Raw mode
    sel = SW'(RAWMODE);
    for (int k = 0; k < 100 && m_mode != RAWMODE; k++) feed_feat(1);
    chk("C mode raw", mode, RAWMODE);
    for (int j = 0; j < 3; j++) begin
      rand_side(); raw_valid = 1'b1; raw_data = RW'(seq[j]); ready = 1'b1;
      feat_valid = 1'($urandom);
      cycle();
      chk("C raw data", data, seq[j]);
      chk("C feat_ready held", feat_ready, 1);
    end

    // Backpressure mid-frame
    rand_side(); raw_valid = 1'b1; raw_data = 1'b1; ready = 1'b1;
    cycle();
    for (int j = 0; j < 10; j++) begin
      rand_side(); raw_valid = 1'b1; raw_data = 1'b0; ready = 1'b0;
      cycle();
      chk("D valid held", valid, 1);
      chk("D data stable", data, 1);
      chk("D raw_ready low", raw_ready, 0);
    end
    ready = 1'b1; raw_valid = 1'b1; raw_data = 1'b0;
    cycle();
    chk("D resumed data", data, 0);

    // Glitch and illegal codes leave the pending mode alone
    sel = SW'(1);
    for (int k = 0; k < 200 && m_mode != 1; k++) begin
      rand_side(); raw_valid = 1'b1; feat_valid = 1'b1; ready = 1'b1;
      cycle();
    end
    chk("E mode 1", mode, 1);
    sel = SW'(2);
    feed_feat(2);
    sel = SW'(1);
    feed_feat(2 * FEATN);
    chk("E glitch ignored", mode, 1);
    sel = SW'(7);
    feed_feat(3 * FEATN);
    chk("E illegal ignored", mode, 1);

    // Asynchronous reset mid-frame
    sel = '0;
    feed_feat(5);
    #2;
    do_reset();
    for (int i = 0; i < FEATN; i++) begin
      rand_side(); feat_valid = 1'b1; ready = 1'b1;
      cycle();
      chk("F frame_done", frame_done, i == FEATN - 1);
      chk("F mode", mode, 0);
    end

    // Randomized traffic
    hold = 0;
    for (int c = 0; c < 5000; c++) begin
      if (hold == 0) begin
        sel  = SW'($urandom_range(0, 7));
        hold = $urandom_range(1, 40);
      end
      hold--;
      rand_side();
      raw_valid  = ($urandom_range(0, 9) < 8);
      feat_valid = ($urandom_range(0, 9) < 8);
      ready      = ($urandom_range(0, 3) != 0);
      if (c == 2500) begin
        #2;
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
